dmem_arbiter: RTL and testbench

//   Shares the single-port 32x32 data memory (async read, posedge-clk write)

---
 rtl/dmem_arbiter_if.sv | 23 ++
 rtl/dmem_arbiter.sv | 107 ++++++++++
 tb/tb_dmem_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Requester-side bundle for the shared data memory.
// master: requester (req/we/addr/wdata out); slave: arbiter.
interface dmem_arbiter_if #(
  parameter int AW = 5,
  parameter int DW = 32
);
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          ack;
  logic [DW-1:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  ack, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output ack, rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for a single-port async-read data memory.
// Ports: clk, rst_n, m0/m1 requester bundles, mem_a/mem_d/mem_we/mem_spo.
module dmem_arbiter #(
  parameter int AW        = 5,
  parameter int DW        = 32,
  parameter int FIXED_PRI = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  dmem_arbiter_if.slave m0,
  dmem_arbiter_if.slave m1,
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] mem_d,
  output logic          mem_we,
  input  logic [DW-1:0] mem_spo
);

  localparam logic RR = (FIXED_PRI == 0);

  typedef enum logic [1:0] {
    IDLE,
    SERVE0,
    SERVE1
  } state_e;

  state_e        state_q, state_d;
  // 1 = m1 was served most recently
  logic          rr_last_q, rr_last_d;
  logic          m0_ack_q, m0_ack_d;
  logic          m1_ack_q, m1_ack_d;
  logic [DW-1:0] m0_rdata_q, m0_rdata_d;
  logic [DW-1:0] m1_rdata_q, m1_rdata_d;
  logic          elig0, elig1, pick1;

  always_comb begin
    state_d    = state_q;
    rr_last_d  = rr_last_q;
    m0_ack_d   = 1'b0;
    m1_ack_d   = 1'b0;
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;
    mem_a      = '0;
    mem_d      = '0;
    mem_we     = 1'b0;
    // A req seen alongside its own ack is the old one.
    elig0 = m0.req & ~m0_ack_q;
    elig1 = m1.req & ~m1_ack_q;
    pick1 = elig1 & (~elig0 | (RR & ~rr_last_q));
    unique case (state_q)
      IDLE: begin
        if (elig0 | elig1) begin
          state_d = pick1 ? SERVE1 : SERVE0;
        end
      end
      SERVE0: begin
        mem_a     = m0.addr;
        mem_d     = m0.wdata;
        mem_we    = m0.we;
        m0_ack_d  = 1'b1;
        rr_last_d = 1'b0;
        state_d   = IDLE;
        if (!m0.we) begin
          m0_rdata_d = mem_spo;
        end
      end
      SERVE1: begin
        mem_a     = m1.addr;
        mem_d     = m1.wdata;
        mem_we    = m1.we;
        m1_ack_d  = 1'b1;
        rr_last_d = 1'b1;
        state_d   = IDLE;
        if (!m1.we) begin
          m1_rdata_d = mem_spo;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Async reset returns to IDLE, which drops mem_we at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rr_last_q  <= 1'b1;
      m0_ack_q   <= 1'b0;
      m1_ack_q   <= 1'b0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_last_q  <= rr_last_d;
      m0_ack_q   <= m0_ack_d;
      m1_ack_q   <= m1_ack_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
    end
  end

  assign m0.ack   = m0_ack_q;
  assign m1.ack   = m1_ack_q;
  assign m0.rdata = m0_rdata_q;
  assign m1.rdata = m1_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: vector table, corner sequences,
// random traffic against a transaction-level model.
module tb_dmem_arbiter;

  localparam logic [31:0] DB = 32'hDEADBEEF;

  logic        clk;
  logic        rst_n;
  logic        tb_load;

  logic [4:0]  mem_a;
  logic [31:0] mem_d;
  logic        mem_we;
  logic [31:0] mem_spo;
  logic [31:0] mem [32];

  logic [4:0]  f_a;
  logic [31:0] f_d;
  logic        f_we;
  logic [31:0] f_spo;
  logic [31:0] fmem [32];

  dmem_arbiter_if #(.AW(5), .DW(32)) m0 ();
  dmem_arbiter_if #(.AW(5), .DW(32)) m1 ();
  dmem_arbiter_if #(.AW(5), .DW(32)) p0 ();
  dmem_arbiter_if #(.AW(5), .DW(32)) p1 ();

  dmem_arbiter #(.AW(5), .DW(32), .FIXED_PRI(0)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .m0      (m0),
    .m1      (m1),
    .mem_a   (mem_a),
    .mem_d   (mem_d),
    .mem_we  (mem_we),
    .mem_spo (mem_spo)
  );

  dmem_arbiter #(.AW(5), .DW(32), .FIXED_PRI(1)) dut_fp (
    .clk     (clk),
    .rst_n   (rst_n),
    .m0      (p0),
    .m1      (p1),
    .mem_a   (f_a),
    .mem_d   (f_d),
    .mem_we  (f_we),
    .mem_spo (f_spo)
  );

  function automatic logic [31:0] preload(int i);
    if (i < 2) return 32'd3;
    if (i == 5) return 32'd0;
    return 32'(i);
  endfunction

  always @(posedge clk) begin
    if (tb_load) begin
      for (int i = 0; i < 32; i++) mem[i] <= preload(i);
    end else if (mem_we) begin
      mem[mem_a] <= mem_d;
    end
  end
  assign mem_spo = mem[mem_a];

  always @(posedge clk) begin
    if (f_we) fmem[f_a] <= f_d;
  end
  assign f_spo = fmem[f_a];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vec_n = 0;
  int bad_n = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    vec_n++;
    if (act !== exp) begin
      bad_n++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        r0, w0;
    logic [4:0]  a0;
    logic [31:0] d0;
    logic        r1, w1;
    logic [4:0]  a1;
    logic [31:0] d1;
    logic        xwe;
    logic [4:0]  xa;
    logic        xk0, xk1;
    logic [31:0] xd0, xd1;
  } vec_t;

  function automatic vec_t v(
    logic r0, w0, logic [4:0] a0, logic [31:0] d0,
    logic r1, w1, logic [4:0] a1, logic [31:0] d1,
    logic xwe, logic [4:0] xa,
    logic xk0, xk1, logic [31:0] xd0, xd1);
    vec_t t;
    t.r0 = r0; t.w0 = w0; t.a0 = a0; t.d0 = d0;
    t.r1 = r1; t.w1 = w1; t.a1 = a1; t.d1 = d1;
    t.xwe = xwe; t.xa = xa;
    t.xk0 = xk0; t.xk1 = xk1;
    t.xd0 = xd0; t.xd1 = xd1;
    return t;
  endfunction

  vec_t tbl[$];

  // transaction-level model state
  logic        rq [2];
  logic        rw [2];
  logic [4:0]  ra [2];
  logic [31:0] rwd [2];
  logic        mk [2];
  logic [31:0] mrd [2];
  logic [31:0] ref_mem [32];
  int          srv;
  int          last;

  task automatic new_fields(input int x);
    rw[x]  = 1'($urandom_range(0, 1));
    ra[x]  = 5'($urandom_range(0, 31));
    rwd[x] = $urandom;
  endtask

  initial begin
    rst_n   = 1'b0;
    tb_load = 1'b1;
    m0.req = 0; m0.we = 0; m0.addr = 0; m0.wdata = 0;
    m1.req = 0; m1.we = 0; m1.addr = 0; m1.wdata = 0;
    p0.req = 0; p0.we = 0; p0.addr = 0; p0.wdata = 0;
    p1.req = 0; p1.we = 0; p1.addr = 0; p1.wdata = 0;

    // both round-robin ties, then single requests
    repeat (8) tbl.push_back(v(1,0,0,0, 1,0,1,0,
                               0,0, 0,0,0,0));
    tbl[1] = v(1,0,0,0, 1,0,1,0, 0,0, 1,0,3,0);
    tbl[2] = v(1,0,0,0, 1,0,1,0, 0,0, 0,0,3,0);
    tbl[3] = v(1,0,0,0, 1,0,1,0, 0,1, 0,1,3,3);
    tbl[4] = v(1,0,0,0, 1,0,1,0, 0,0, 0,0,3,3);
    tbl[5] = v(1,0,0,0, 1,0,1,0, 0,0, 1,0,3,3);
    tbl[6] = v(1,0,0,0, 1,0,1,0, 0,0, 0,0,3,3);
    tbl[7] = v(1,0,0,0, 1,0,1,0, 0,1, 0,1,3,3);
    tbl.push_back(v(0,0,0,0,  0,0,0,0,  0,0,  0,0,3,3));
    tbl.push_back(v(1,0,20,0, 0,0,0,0,  0,0,  0,0,3,3));
    tbl.push_back(v(1,0,20,0, 0,0,0,0,  0,20, 1,0,20,3));
    tbl.push_back(v(0,0,0,0,  0,0,0,0,  0,0,  0,0,20,3));
    tbl.push_back(v(0,0,0,0,  1,1,7,DB, 0,0,  0,0,20,3));
    tbl.push_back(v(0,0,0,0,  1,1,7,DB, 1,7,  0,1,20,3));
    tbl.push_back(v(1,0,7,0,  0,1,7,DB, 0,0,  0,0,20,3));
    tbl.push_back(v(1,0,7,0,  0,1,7,DB, 0,7,  1,0,DB,3));
    tbl.push_back(v(0,0,0,0,  0,0,0,0,  0,0,  0,0,DB,3));
    // m0 keeps req through its ack cycle
    tbl.push_back(v(1,0,20,0, 0,0,0,0,  0,0,  0,0,DB,3));
    tbl.push_back(v(1,0,20,0, 0,0,0,0,  0,20, 1,0,20,3));
    tbl.push_back(v(1,0,20,0, 0,0,0,0,  0,0,  0,0,20,3));
    tbl.push_back(v(1,0,20,0, 0,0,0,0,  0,0,  0,0,20,3));
    tbl.push_back(v(1,0,20,0, 0,0,0,0,  0,20, 1,0,20,3));
    tbl.push_back(v(0,0,0,0,  0,0,0,0,  0,0,  0,0,20,3));

    #2;
    chk("rst_we", mem_we, 0);
    chk("rst_ack0", m0.ack, 0);
    chk("rst_ack1", m1.ack, 0);
    chk("rst_rd0", m0.rdata, 0);
    chk("rst_rd1", m1.rdata, 0);
    chk("rst_fp_ack", {p0.ack, p1.ack}, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n   = 1'b1;
    tb_load = 1'b0;

    foreach (tbl[i]) begin
      @(negedge clk);
      m0.req = tbl[i].r0; m0.we = tbl[i].w0;
      m0.addr = tbl[i].a0; m0.wdata = tbl[i].d0;
      m1.req = tbl[i].r1; m1.we = tbl[i].w1;
      m1.addr = tbl[i].a1; m1.wdata = tbl[i].d1;
      #1;
      chk($sformatf("t%0d_we", i), mem_we, tbl[i].xwe);
      chk($sformatf("t%0d_a", i), mem_a, tbl[i].xa);
      @(posedge clk);
      #1;
      chk($sformatf("t%0d_k0", i), m0.ack, tbl[i].xk0);
      chk($sformatf("t%0d_k1", i), m1.ack, tbl[i].xk1);
      chk($sformatf("t%0d_d0", i), m0.rdata, tbl[i].xd0);
      chk($sformatf("t%0d_d1", i), m1.rdata, tbl[i].xd1);
    end
    chk("w7_mem", mem[7], DB);

    // reset in the middle of an m1 write
    @(negedge clk);
    m1.req = 1; m1.we = 1; m1.addr = 5; m1.wdata = 9;
    @(negedge clk);
    #1;
    chk("ab_we_pre", mem_we, 1);
    chk("ab_a_pre", mem_a, 5);
    rst_n = 1'b0;
    #1;
    chk("ab_we_async", mem_we, 0);
    chk("ab_ack1", m1.ack, 0);
    chk("ab_rd0_clr", m0.rdata, 0);
    @(posedge clk);
    #1;
    chk("ab_mem5", mem[5], 0);
    chk("ab_ack1_b", m1.ack, 0);
    @(negedge clk);
    rst_n  = 1'b1;
    m1.req = 0;
    @(posedge clk);
    #1;
    chk("ab_ack1_c", m1.ack, 0);
    @(negedge clk);
    #1;
    chk("ab_idle_we", mem_we, 0);
    m0.req = 1; m0.we = 0; m0.addr = 20;
    @(negedge clk);
    #1;
    chk("ab_serve_a", mem_a, 20);
    @(posedge clk);
    #1;
    chk("ab_ack0", m0.ack, 1);
    chk("ab_rd0", m0.rdata, 20);
    @(negedge clk);
    m0.req = 0;

    // fixed priority: m0 wins a tie even right after m0
    @(negedge clk);
    p0.req = 1; p0.we = 0; p0.addr = 3;
    @(negedge clk);
    #1;
    chk("fp_a3", f_a, 3);
    @(posedge clk);
    #1;
    chk("fp_ack0_a", p0.ack, 1);
    @(negedge clk);
    p0.req = 0;
    @(negedge clk);
    p0.req = 1; p0.addr = 4;
    p1.req = 1; p1.we = 0; p1.addr = 9;
    @(negedge clk);
    #1;
    chk("fp_tie_a", f_a, 4);
    @(posedge clk);
    #1;
    chk("fp_ack0_b", p0.ack, 1);
    chk("fp_ack1_b", p1.ack, 0);
    @(negedge clk);
    p0.req = 0;
    #1;
    chk("fp_idle_a", f_a, 0);
    @(negedge clk);
    #1;
    chk("fp_m1_a", f_a, 9);
    @(posedge clk);
    #1;
    chk("fp_ack1_c", p1.ack, 1);
    chk("fp_ack0_c", p0.ack, 0);
    @(negedge clk);
    p1.req = 0;

    // random traffic vs model
    @(negedge clk);
    rst_n   = 1'b0;
    tb_load = 1'b1;
    m0.req = 0;
    m1.req = 0;
    @(posedge clk);
    @(negedge clk);
    rst_n   = 1'b1;
    tb_load = 1'b0;
    for (int i = 0; i < 32; i++) ref_mem[i] = preload(i);
    for (int x = 0; x < 2; x++) begin
      rq[x] = 0; mk[x] = 0; mrd[x] = 0;
      new_fields(x);
    end
    srv  = -1;
    last = 1;

    for (int c = 0; c < 2000; c++) begin
      logic e0, e1;
      logic [31:0] xd;
      logic [4:0]  xa;
      logic        xw;
      @(negedge clk);
      for (int x = 0; x < 2; x++) begin
        if (mk[x]) begin
          rq[x] = 1'($urandom_range(0, 1));
          new_fields(x);
        end else if (!rq[x]) begin
          rq[x] = ($urandom_range(0, 2) == 0);
          new_fields(x);
        end else if (srv == x &&
                     $urandom_range(0, 7) == 0) begin
          rq[x] = 0;
        end
      end
      m0.req = rq[0]; m0.we = rw[0];
      m0.addr = ra[0]; m0.wdata = rwd[0];
      m1.req = rq[1]; m1.we = rw[1];
      m1.addr = ra[1]; m1.wdata = rwd[1];
      #1;
      xw = 0; xa = 0; xd = 0;
      if (srv >= 0) begin
        xw = rw[srv]; xa = ra[srv]; xd = rwd[srv];
      end
      chk("r_we", mem_we, xw);
      chk("r_a", mem_a, xa);
      chk("r_d", mem_d, xd);
      if (srv >= 0) begin
        if (rw[srv]) ref_mem[ra[srv]] = rwd[srv];
        else mrd[srv] = ref_mem[ra[srv]];
        mk[0] = (srv == 0);
        mk[1] = (srv == 1);
        last  = srv;
        srv   = -1;
      end else begin
        e0 = rq[0] && !mk[0];
        e1 = rq[1] && !mk[1];
        mk[0] = 0;
        mk[1] = 0;
        if (e0 && e1) srv = (last == 0) ? 1 : 0;
        else if (e0) srv = 0;
        else if (e1) srv = 1;
      end
      @(posedge clk);
      #1;
      chk("r_ack0", m0.ack, mk[0]);
      chk("r_ack1", m1.ack, mk[1]);
      chk("r_rd0", m0.rdata, mrd[0]);
      chk("r_rd1", m1.rdata, mrd[1]);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vec_n, bad_n);
    $finish;
  end

endmodule
